// File: rtl/configure.sv
// Shared definitions for uart_fifo: register offsets, FSM state encoding, STATUS bit positions.
// UART_PARITY_EN adds the PARITY state used by both the TX and RX FSMs.
package configure;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_t;

  localparam int unsigned STAT_TX_FULL    = 0;
  localparam int unsigned STAT_TX_EMPTY   = 1;
  localparam int unsigned STAT_RX_FULL    = 2;
  localparam int unsigned STAT_RX_EMPTY   = 3;
  localparam int unsigned STAT_OVERRUN    = 4;
  localparam int unsigned STAT_FRAME_ERR  = 5;
  localparam int unsigned STAT_PARITY_ERR = 6;
  localparam int unsigned STAT_RX_COUNT   = 8;
  localparam int unsigned STAT_TX_COUNT   = 16;

  localparam logic [15:0] DIV_MIN = 16'd4;

endpackage

// File: rtl/uart_fifo_buf.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module uart_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable divisor, sticky errors and level IRQ.
// Define UART_PARITY_EN for an even-parity bit between DATA and STOP (8E1 instead of 8N1).
module uart_fifo
  import configure::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   div;
  logic          rx_irq_en, tx_irq_en;
  logic          overrun, frame_err, parity_err;
  logic          frame_set, parity_set;
  logic          tx_push_q, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_byte_q, tx_head;
  logic [CW-1:0] tx_count;
  logic          rx_push_q, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_byte_q, rx_head;
  logic [CW-1:0] rx_count;
  logic [1:0]    sel;
  logic          is_wr, is_rd;
  logic [31:0]   rdata_next;
  logic          unused;

  assign unused = ^{uart_instr, uart_addr[31:4], uart_addr[1:0], uart_wdata[31:16]};

  assign sel    = uart_addr[3:2];
  assign is_wr  = uart_valid & (|uart_wstrb);
  assign is_rd  = uart_valid & ~(|uart_wstrb);
  assign rx_pop = is_rd & (sel == UART_DATA);

  assign uart_irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);

  uart_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(tx_push_q), .wdata(tx_byte_q), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push_q), .wdata(rx_byte_q), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    rdata_next = '0;
    case (sel)
      UART_DATA:   rdata_next = rx_empty ? '0 : {24'd0, rx_head};
      UART_STATUS: begin
        rdata_next[STAT_TX_FULL]    = tx_full;
        rdata_next[STAT_TX_EMPTY]   = tx_empty;
        rdata_next[STAT_RX_FULL]    = rx_full;
        rdata_next[STAT_RX_EMPTY]   = rx_empty;
        rdata_next[STAT_OVERRUN]    = overrun;
        rdata_next[STAT_FRAME_ERR]  = frame_err;
        rdata_next[STAT_PARITY_ERR] = parity_err;
        rdata_next[STAT_RX_COUNT +: 8] = 8'(rx_count);
        rdata_next[STAT_TX_COUNT +: 8] = 8'(tx_count);
      end
      UART_DIV:    rdata_next = {16'd0, div};
      UART_CTRL:   rdata_next = {30'd0, tx_irq_en, rx_irq_en};
      default:     rdata_next = '0;
    endcase
  end

  // TX pushes are applied the cycle after the request so they line up with uart_ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_ready <= 1'b0;
      uart_rdata <= '0;
      tx_push_q  <= 1'b0;
      tx_byte_q  <= '0;
      div        <= DIV_RESET;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      uart_ready <= uart_valid;
      uart_rdata <= is_rd ? rdata_next : '0;
      tx_push_q  <= is_wr & (sel == UART_DATA) & uart_wstrb[0];
      tx_byte_q  <= uart_wdata[7:0];
      if (is_wr && sel == UART_DIV)
        div <= (uart_wdata[15:0] < DIV_MIN) ? DIV_MIN : uart_wdata[15:0];
      if (is_wr && sel == UART_CTRL) begin
        rx_irq_en <= uart_wdata[0];
        tx_irq_en <= uart_wdata[1];
        if (uart_wdata[2]) begin
          overrun    <= 1'b0;
          frame_err  <= 1'b0;
          parity_err <= 1'b0;
        end
      end
      if (rx_push_q && rx_full && !rx_pop) overrun <= 1'b1;
      if (frame_set)  frame_err  <= 1'b1;
      if (parity_set) parity_err <= 1'b1;
    end
  end

  // ---------------- TX ----------------
  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
`ifdef UART_PARITY_EN
  logic        tx_par;
`endif

  // The next byte is launched straight out of STOP so frames are back to back.
  assign tx_pop = ~tx_empty & ((tx_state == ST_IDLE) | ((tx_state == ST_STOP) & (tx_cnt == '0)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_state <= ST_START;
      tx_cnt   <= div - 1'b1;
      tx_sh    <= tx_head;
      uart_tx  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else begin
      case (tx_state)
        ST_IDLE: uart_tx <= 1'b1;
        ST_START:
          if (tx_cnt == '0) begin
            tx_state <= ST_DATA;
            tx_cnt   <= div - 1'b1;
            tx_bit   <= '0;
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
          end else tx_cnt <= tx_cnt - 1'b1;
        ST_DATA:
          if (tx_cnt == '0) begin
            tx_cnt <= div - 1'b1;
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_state <= ST_PARITY;
              uart_tx  <= tx_par;
`else
              tx_state <= ST_STOP;
              uart_tx  <= 1'b1;
`endif
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
            end
          end else tx_cnt <= tx_cnt - 1'b1;
`ifdef UART_PARITY_EN
        ST_PARITY:
          if (tx_cnt == '0) begin
            tx_state <= ST_STOP;
            tx_cnt   <= div - 1'b1;
            uart_tx  <= 1'b1;
          end else tx_cnt <= tx_cnt - 1'b1;
`endif
        ST_STOP:
          if (tx_cnt == '0) begin
            tx_state <= ST_IDLE;
            uart_tx  <= 1'b1;
          end else tx_cnt <= tx_cnt - 1'b1;
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  uart_state_t rx_state;
  logic        rx_meta, rx_sync, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
`ifdef UART_PARITY_EN
  logic        rx_par_bad;
`else
  assign parity_set = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_push_q  <= 1'b0;
      rx_byte_q  <= '0;
      frame_set  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      parity_set <= 1'b0;
`endif
    end else begin
      rx_push_q <= 1'b0;
      frame_set <= 1'b0;
`ifdef UART_PARITY_EN
      parity_set <= 1'b0;
`endif
      case (rx_state)
        ST_IDLE:
          if (!rx_sync && rx_prev) begin
            rx_state <= ST_START;
            rx_cnt   <= (div >> 1) - 1'b1;
          end
        ST_START:
          if (rx_cnt == '0) begin
            if (rx_sync) rx_state <= ST_IDLE;
            else begin
              rx_state <= ST_DATA;
              rx_cnt   <= div - 1'b1;
              rx_bit   <= '0;
            end
          end else rx_cnt <= rx_cnt - 1'b1;
        ST_DATA:
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_cnt <= div - 1'b1;
            rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_bit == 3'd7) rx_state <= ST_PARITY;
`else
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
`endif
          end else rx_cnt <= rx_cnt - 1'b1;
`ifdef UART_PARITY_EN
        ST_PARITY:
          if (rx_cnt == '0) begin
            rx_par_bad <= rx_sync ^ (^rx_sh);
            rx_state   <= ST_STOP;
            rx_cnt     <= div - 1'b1;
          end else rx_cnt <= rx_cnt - 1'b1;
`endif
        ST_STOP:
          if (rx_cnt == '0) begin
            rx_state <= ST_IDLE;
            if (!rx_sync) frame_set <= 1'b1;
            else begin
              rx_push_q <= 1'b1;
              rx_byte_q <= rx_sh;
`ifdef UART_PARITY_EN
              parity_set <= rx_par_bad;
`endif
            end
          end else rx_cnt <= rx_cnt - 1'b1;
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Memory-mapped UART peripheral for the soc uart bus, replacing the fixed-rate single-byte UART. It adds parametrised-depth TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and a level interrupt. It sits beside `soc` in `top` on the `uart_*` request/response bus and drives the `uart_tx`/`uart_rx` pins.

## Interface
- `FIFO_DEPTH`, default 16: entries per FIFO; must be a power of two, at least 2.
- `DIV_RESET`, default 868: reset value of the DIV register, in clocks per bit.
- `reset`  in  1  asynchronous, active-low; low holds the block in reset.
- `clock`  in  1  single clock; all logic is on the rising edge.
- `uart_valid`  in  1  one-cycle request strobe.
- `uart_instr`  in  1  ignored; fetch requests are treated as reads.
- `uart_addr`  in  32  byte address; only bits [3:2] are decoded.
- `uart_wdata`  in  32  write data.
- `uart_wstrb`  in  4  byte strobes; zero means read.
- `uart_rdata`  out  32  read data, valid while `uart_ready` is high.
- `uart_ready`  out  1  one-cycle response pulse.
- `uart_rx`  in  1  serial input; asynchronous, idles high.
- `uart_tx`  out  1  serial output; idles high.
- `uart_irq`  out  1  level interrupt.

## Operation
- Register map, selected by `addr[3:2]`:
  - 0 DATA
    - Write with `wstrb[0]=1`: pushes `wdata[7:0]` into the TX FIFO. The push is dropped if the FIFO is full.
    - Read: pops the RX FIFO and returns the byte zero-extended. Returns 0 with no pop if the FIFO is empty.
  - 1 STATUS, read-only
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
    - bit4 overrun (sticky), bit5 frame_err (sticky), bit6 parity_err (sticky; always 0 without the macro).
    - bits [15:8] rx_count, bits [23:16] tx_count.
  - 2 DIV: read/write, bits [15:0], clocks per bit. Writes below 4 store 4.
  - 3 CTRL
    - bit0 rx_irq_en, bit1 tx_irq_en; read/write.
    - bit2: writing 1 clears all sticky error flags; always reads 0.
- `uart_irq` = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty).
- TX FSM, states IDLE → START → DATA → (PARITY) → STOP → IDLE:
  - IDLE leaves when the TX FIFO is not empty; the head byte is popped on that transition.
  - Each state lasts DIV clocks.
  - Data is sent LSB first, 8 bits. There is one stop bit.
  - STOP returns to IDLE; the next byte can start in the very next cycle, with no idle gap.
- RX FSM, states IDLE → START → DATA → (PARITY) → STOP → IDLE:
  - `uart_rx` passes through a 2-flop synchroniser.
  - A synchronised falling edge in IDLE enters START.
  - START samples at DIV/2 (integer division). If the sample is high it is a glitch and the FSM returns to IDLE with nothing pushed.
  - Later samples are taken every DIV clocks after that midpoint.
  - STOP sample low: set frame_err and discard the byte.
  - Good byte with the RX FIFO full: set overrun and discard the new byte; FIFO contents are unchanged.
- A DIV write takes effect at the start of the next bit. A frame in flight is not corrupted beyond that.

## Timing
- Bus: `uart_ready` pulses exactly one cycle after each `uart_valid` cycle, with `uart_rdata` valid in that same cycle. Back-to-back valids give back-to-back readys.
- A write and its FIFO push are visible in STATUS one cycle after `uart_ready`.
- A TX byte reaches the `uart_tx` start edge 2 cycles after `uart_ready` when the TX FSM is idle.
- RX push occurs 1 cycle after the STOP sample.
- Simultaneous FIFO push and pop: both happen and the count is unchanged. This includes a push while full, which is allowed only when a pop happens in the same cycle.
- Reset values:
  - `uart_tx`=1, `uart_ready`=0, `uart_rdata`=0, `uart_irq`=0.
  - Both FIFOs empty, DIV=`DIV_RESET`, CTRL=0, flags=0.
  - Both FSMs in IDLE.
- Reset asserted mid-frame aborts immediately; `uart_tx` returns high asynchronously.

## Configuration
- `UART_PARITY_EN` defined: an even-parity bit is sent and checked between DATA and STOP.
  - On an RX parity mismatch the byte is still pushed and parity_err is set.
- `UART_PARITY_EN` undefined: no PARITY state exists, the frame is 8N1, and STATUS bit6 reads 0.

## Structure
- The shared `configure` package holds:
  - the register offset constants (`UART_DATA`, `UART_STATUS`, `UART_DIV`, `UART_CTRL`);
  - the `uart_state_t` enum used by both FSMs;
  - the status bit index constants.
- Sub-module `uart_fifo_buf`: synchronous FIFO parametrised by width and depth, with push/pop/full/empty/count outputs. It is instantiated twice, once for TX and once for RX.

## Test plan
- Reset, then read STATUS → 0x0000_000A (tx_empty, rx_empty); read DIV → 868.
- Write DIV=16; write DATA 0x55 → `uart_tx` shows a 16-clock start bit low, then 1,0,1,0,1,0,1,0, then a stop bit high; total 160 clocks, or 176 with parity.
- Drive an RX frame 0xA3 at DIV=16 into `uart_rx` → rx_count=1; read DATA → 0xA3, after which rx_empty=1.
- Send `FIFO_DEPTH`+1 RX frames without reading → overrun=1 and rx_count=`FIFO_DEPTH`. Reads return the first `FIFO_DEPTH` bytes in order. CTRL write 0x4 clears the flag.
- Send an RX frame with stop bit low → frame_err=1 and no push. Send an 8-clock low glitch at DIV=16 → no push and no error.
- Write 17 TX bytes with `FIFO_DEPTH`=16 while idle → the first byte starts immediately and 16 stay queued. With tx_irq_en=1, `uart_irq` rises when the last byte is popped. Assert reset mid-frame → `uart_tx`=1 at once.
